// File: rtl/pipe_stage_if.sv
// pipe_stage_if
//   Bundle of the upstream handshake, downstream handshake, pipeline control
//   and observation signals of one pipeline-stage register.
//
//   Handshake semantics (both sides): a transfer happens on a rising clock
//   edge where valid and ready are both 1. A producer that raises valid keeps
//   it and its payload steady until the transfer. flush and stall override
//   the handshake: under stall nothing moves, and under flush every held entry
//   and any input offered that cycle are dropped.
//
//   modport master : the surrounding pipeline (drives inputs, sees status)
//   modport slave  : the stage register itself
interface pipe_stage_if #(
    parameter int DATA_W = 145,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, flush, stall, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, stall, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Reusable handshaked pipeline-stage register carrying an opaque datapath
//   bundle and a control bundle. Supports flush (bubble injection), stall
//   (freeze) and valid/ready flow control. With SKID=1 a second entry absorbs
//   one input while the main entry is blocked, so in_ready is driven from a
//   flop instead of from out_ready.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - pipe_stage_if.slave: in_valid/in_ready/in_data/in_ctrl,
//            flush, stall, out_valid/out_ready/out_data/out_ctrl,
//            occupancy (held entries), stall_cnt (saturating stall cycles)
module pipe_stage_reg #(
    parameter int DATA_W = 145,
    parameter int CTRL_W = 11,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_stage_if.slave bus
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic in_ready;
    logic in_fire;
    logic main_free;

    // Without a skid entry the stage can accept whenever its only entry is
    // empty or leaving. With a skid entry, acceptance depends only on the
    // skid flop, which cuts the combinational out_ready -> in_ready path.
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = ~bus.stall & ~skid_valid_q;
        end else begin
            in_ready = ~bus.stall & (~main_valid_q | bus.out_ready);
        end
    end

    // An input offered during flush is dropped even if in_ready is high.
    assign in_fire   = bus.in_valid & in_ready & ~bus.flush;
    assign main_free = ~main_valid_q | bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        stall_cnt_d  = stall_cnt_q;

        if (bus.flush) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
        end else if (bus.stall) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (SKID == 0) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = bus.in_data;
                main_ctrl_d  = bus.in_ctrl;
            end else if (main_valid_q && bus.out_ready) begin
                // Data is left in place; only ctrl must read as a bubble.
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else begin
            if (main_free) begin
                if (skid_valid_q) begin
                    // The older skid entry always moves up first.
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    main_ctrl_d  = skid_ctrl_q;
                    if (in_fire) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = bus.in_data;
                        skid_ctrl_d  = bus.in_ctrl;
                    end else begin
                        skid_valid_d = 1'b0;
                        skid_data_d  = '0;
                        skid_ctrl_d  = '0;
                    end
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = bus.in_data;
                    main_ctrl_d  = bus.in_ctrl;
                end else begin
                    main_valid_d = 1'b0;
                    main_ctrl_d  = '0;
                end
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.in_data;
                skid_ctrl_d  = bus.in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid_q;
    assign bus.out_data  = main_data_q;
    // Gate ctrl as well so a bubble can never carry a write enable.
    assign bus.out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign bus.occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign bus.stall_cnt = stall_cnt_q;

endmodule
